// File: rtl/bomberman_pkg.sv
// Shared types and screen constants for the bomb blast logic.
package bomberman_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FUSE     = 2'd1,
    BLAST    = 2'd2,
    COOLDOWN = 2'd3
  } blast_state_t;

  localparam int PIX_W        = 10;
  localparam int SCREEN_X_MAX = 639;
  localparam int SCREEN_Y_MAX = 479;

  // Unsigned |a-b|; the larger operand is always the minuend, so nothing wraps.
  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/frame_down_counter.sv
// Loadable down counter shared by the fuse, blast and cooldown phases.
module frame_down_counter #(
  parameter int W = 7
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_zero
);

  logic [W-1:0] r_value;

  // Load has priority over decrement; the FSM only enables counting while nonzero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_value <= '0;
    end else if (i_load) begin
      r_value <= i_load_val;
    end else if (i_en) begin
      r_value <= r_value - 1'b1;
    end
  end

  assign o_zero = (r_value == '0);

endmodule

// File: rtl/bomb_blast_ctrl.sv
// Fuse timer, explode pulse, clamped cross-shaped blast region and player hit test.
module bomb_blast_ctrl
  import bomberman_pkg::*;
#(
  parameter int FUSE_FRAMES     = 120,
  parameter int BLAST_FRAMES    = 30,
  parameter int COOLDOWN_FRAMES = 15,
  parameter int BLAST_RANGE     = 32,
  parameter int ARM_HALF        = 4
) (
  input  logic             i_frame_clk,
  input  logic             i_reset_n,
  input  logic             i_bomb_check,
  input  logic [PIX_W-1:0] i_bomb_x,
  input  logic [PIX_W-1:0] i_bomb_y,
  input  logic [PIX_W-1:0] i_user_x,
  input  logic [PIX_W-1:0] i_user_y,
  output logic             o_explode,
  output logic             o_blast_active,
  output logic [PIX_W-1:0] o_blast_x_min,
  output logic [PIX_W-1:0] o_blast_x_max,
  output logic [PIX_W-1:0] o_blast_y_min,
  output logic [PIX_W-1:0] o_blast_y_max,
  output logic             o_player_hit,
  output logic             o_busy
);

  localparam int MAX_FB     = (FUSE_FRAMES > BLAST_FRAMES) ? FUSE_FRAMES : BLAST_FRAMES;
  localparam int MAX_FRAMES = (MAX_FB > COOLDOWN_FRAMES) ? MAX_FB : COOLDOWN_FRAMES;
  localparam int CNT_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
  localparam int PW1        = PIX_W + 1;

  localparam logic [CNT_W-1:0] FUSE_LOAD  = CNT_W'(FUSE_FRAMES - 1);
  localparam logic [CNT_W-1:0] BLAST_LOAD = CNT_W'(BLAST_FRAMES - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD  = CNT_W'(COOLDOWN_FRAMES - 1);

  localparam logic [PIX_W-1:0] RANGE_N = PIX_W'(BLAST_RANGE);
  localparam logic [PIX_W-1:0] ARM_N   = PIX_W'(ARM_HALF);
  localparam logic [PW1-1:0]   RANGE_W = PW1'(BLAST_RANGE);
  localparam logic [PW1-1:0]   X_CEIL  = PW1'(SCREEN_X_MAX);
  localparam logic [PW1-1:0]   Y_CEIL  = PW1'(SCREEN_Y_MAX);

  blast_state_t     r_state, w_state_next;
  logic [PIX_W-1:0] r_bx, r_by;
  logic             w_latch;
  logic             w_cnt_load, w_cnt_en, w_cnt_zero;
  logic [CNT_W-1:0] w_cnt_load_val;
  logic             w_explode_next;
  logic             w_in_blast_next;

  logic [PW1-1:0]   w_x_sum, w_y_sum;
  logic [PIX_W-1:0] w_x_min, w_x_max, w_y_min, w_y_max;
  logic [PIX_W-1:0] w_dx, w_dy;
  logic             w_h_arm, w_v_arm;

  logic             r_explode, r_blast_active, r_player_hit, r_busy;
  logic [PIX_W-1:0] r_x_min, r_x_max, r_y_min, r_y_max;

  frame_down_counter #(.W(CNT_W)) u_frame_cnt (
    .i_clk      (i_frame_clk),
    .i_rst_n    (i_reset_n),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_load_val),
    .i_en       (w_cnt_en),
    .o_zero     (w_cnt_zero)
  );

  // Extents: lower edge guarded against underflow, upper edge summed in 11 bits then clamped.
  assign w_x_sum = {1'b0, r_bx} + RANGE_W;
  assign w_y_sum = {1'b0, r_by} + RANGE_W;
  assign w_x_min = (r_bx < RANGE_N) ? '0 : (r_bx - RANGE_N);
  assign w_y_min = (r_by < RANGE_N) ? '0 : (r_by - RANGE_N);
  assign w_x_max = (w_x_sum > X_CEIL) ? X_CEIL[PIX_W-1:0] : w_x_sum[PIX_W-1:0];
  assign w_y_max = (w_y_sum > Y_CEIL) ? Y_CEIL[PIX_W-1:0] : w_y_sum[PIX_W-1:0];

  // Hit test against the cross: each arm is a thin band around the bomb centre.
  assign w_dx    = abs_diff(i_user_x, r_bx);
  assign w_dy    = abs_diff(i_user_y, r_by);
  assign w_h_arm = (w_dy <= ARM_N) && (i_user_x >= w_x_min) && (i_user_x <= w_x_max);
  assign w_v_arm = (w_dx <= ARM_N) && (i_user_y >= w_y_min) && (i_user_y <= w_y_max);

  // State register.
  always_ff @(posedge i_frame_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and counter control; abort in FUSE outranks terminal count.
  always_comb begin
    w_state_next   = r_state;
    w_latch        = 1'b0;
    w_cnt_load     = 1'b0;
    w_cnt_load_val = '0;
    w_cnt_en       = 1'b0;
    w_explode_next = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_bomb_check) begin
          w_state_next   = FUSE;
          w_latch        = 1'b1;
          w_cnt_load     = 1'b1;
          w_cnt_load_val = FUSE_LOAD;
        end
      end
      FUSE: begin
        if (!i_bomb_check) begin
          w_state_next = IDLE;
        end else if (w_cnt_zero) begin
          w_state_next   = BLAST;
          w_cnt_load     = 1'b1;
          w_cnt_load_val = BLAST_LOAD;
          w_explode_next = 1'b1;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      BLAST: begin
        if (w_cnt_zero) begin
          w_state_next   = COOLDOWN;
          w_cnt_load     = 1'b1;
          w_cnt_load_val = COOL_LOAD;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      COOLDOWN: begin
        if (w_cnt_zero) begin
          w_state_next = IDLE;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_in_blast_next = (w_state_next == BLAST);

  // Bomb centre is captured only on acceptance, so it stays fixed through the blast.
  always_ff @(posedge i_frame_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_bx <= '0;
      r_by <= '0;
    end else if (w_latch) begin
      r_bx <= i_bomb_x;
      r_by <= i_bomb_y;
    end
  end

  // Output registers, all aligned with the state they describe.
  always_ff @(posedge i_frame_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_explode      <= 1'b0;
      r_blast_active <= 1'b0;
      r_x_min        <= '0;
      r_x_max        <= '0;
      r_y_min        <= '0;
      r_y_max        <= '0;
      r_player_hit   <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_explode      <= w_explode_next;
      r_blast_active <= w_in_blast_next;
      r_x_min        <= w_in_blast_next ? w_x_min : '0;
      r_x_max        <= w_in_blast_next ? w_x_max : '0;
      r_y_min        <= w_in_blast_next ? w_y_min : '0;
      r_y_max        <= w_in_blast_next ? w_y_max : '0;
      r_player_hit   <= w_in_blast_next && (w_h_arm || w_v_arm);
      r_busy         <= (w_state_next != IDLE);
    end
  end

  assign o_explode      = r_explode;
  assign o_blast_active = r_blast_active;
  assign o_blast_x_min  = r_x_min;
  assign o_blast_x_max  = r_x_max;
  assign o_blast_y_min  = r_y_min;
  assign o_blast_y_max  = r_y_max;
  assign o_player_hit   = r_player_hit;
  assign o_busy         = r_busy;

endmodule
